logic_op_sequencer: RTL and testbench
=====================================

// Module: logic_op_sequencer
//
// PURPOSE
// Clocked initiator for the 2-bit logic-op unit (00 AND, 01 OR, 10 XOR, 11 NAND).
// - On start, captures one operand pair and steps all four opcodes in order, one per cycle.
// - Registers each result and accumulates an XOR checksum and an OR summary.
// - Fully registered with complete assignments: no inferred storage; every op has a defined result.
//
// PARAMETERS
// WIDTH   16   operand/result width in bits
//
// PORTS
// clk           in   1      rising-edge clock
// reset         in   1      asynchronous, active-high reset
// start         in   1      request a sweep; sampled only in IDLE
// pause         in   1      in RUN: hold current step, no result this cycle
// a             in   WIDTH  operand A; captured on accepted start
// b             in   WIDTH  operand B; captured on accepted start
// busy          out  1      1 while a sweep is in progress
// op            out  2      opcode of the result currently on x
// x             out  WIDTH  registered result for op
// result_valid  out  1      1-cycle strobe: x/op hold a new result
// y             out  WIDTH  XOR of all results produced this sweep
// z             out  WIDTH  OR of all results produced this sweep
// done          out  1      1-cycle strobe: sweep complete, y/z final
//
// BEHAVIOUR
// - Reset (any time, async): state=IDLE, step=0, busy=0, op=0, x=0, result_valid=0, y=0, z=0, done=0.
// - States: IDLE, RUN. No other states; any illegal encoding recovers to IDLE.
// - IDLE: start=1 at edge E0 -> a_q<=a, b_q<=b, y<=0, z<=0, step<=0, busy<=1, go RUN.
// - IDLE, start=0: all registers hold; result_valid=0, done=0.
// - RUN edge with pause=0: f=F(step,a_q,b_q).
//   - x<=f, op<=step, result_valid<=1, y<=y^f, z<=z|f, step<=step+1.
// - F: 00 a&b, 01 a|b, 10 a^b, 11 ~(a&b); full WIDTH, no truncation or extension.
// - RUN edge with pause=1: step, x, op, y, z hold; result_valid<=0.
// - Latency: unpaused sweep yields results after E1..E4 (op 00,01,10,11).
//   After E4: done=1, busy=0, state=IDLE (same cycle as last result_valid).
// - Step wraps 11->00 only on completion; never re-enters RUN without a new start.
// - start while busy=1: ignored; a/b changes during RUN have no effect (captured copies used).
// - start in the cycle done=1: accepted (busy=0); y/z cleared at that edge; new sweep begins.
// - pause in IDLE: no effect. x/op/y/z retain last values after done until next start/reset.
// - Reset mid-sweep: sweep abandoned, no done pulse, outputs to reset values.
//
// TESTING
// 1. a=16'h00F0, b=16'h0FF0, start 1 cycle -> x=00F0,0FF0,0F00,FF0F on E1..E4 with op=0..3;
//    done after E4 with y=16'hFF0F, z=16'hFFFF.
// 2. Same as 1, pause high at E2,E3 -> result_valid low 2 cycles, same x sequence, done after E6.
// 3. start re-asserted during RUN and a/b changed mid-sweep -> ignored; results/y/z identical to test 1.
// 4. Reset asserted between E2 and E3 -> immediate busy=0, x=0, y=0, z=0; no done; later start runs clean.
// 5. Back-to-back: start held high -> second sweep accepted in done cycle; y/z restart from 0.
// 6. a=16'hFFFF, b=16'h0000 -> x=0000,FFFF,FFFF,FFFF; y=16'hFFFF, z=16'hFFFF.

Source files
------------

// File: rtl/logic_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : logic_op_sequencer
// Description : Captures one operand pair on start and steps AND/OR/XOR/NAND,
//               registering each result plus XOR/OR accumulations of them.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_op_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [1:0]       op,
  output logic [WIDTH-1:0] x,
  output logic             result_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z,
  output logic             done
);

  localparam logic [1:0] c_last_step = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_step, w_step_nx;
  logic [WIDTH-1:0] r_a, r_b, w_a_nx, w_b_nx;
  logic [WIDTH-1:0] w_f;
  logic             w_busy_nx, w_rv_nx, w_done_nx;
  logic [1:0]       w_op_nx;
  logic [WIDTH-1:0] w_x_nx, w_y_nx, w_z_nx;

  always_comb begin
    w_f = '0;
    case (r_step)
      2'b00:   w_f = r_a & r_b;
      2'b01:   w_f = r_a | r_b;
      2'b10:   w_f = r_a ^ r_b;
      default: w_f = ~(r_a & r_b);
    endcase
  end

  // Everything holds by default; only the two strobes fall back to 0.
  always_comb begin
    w_state_nx = r_state;
    w_step_nx  = r_step;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_busy_nx  = busy;
    w_op_nx    = op;
    w_x_nx     = x;
    w_y_nx     = y;
    w_z_nx     = z;
    w_rv_nx    = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nx     = a;
          w_b_nx     = b;
          w_y_nx     = '0;
          w_z_nx     = '0;
          w_step_nx  = 2'b00;
          w_busy_nx  = 1'b1;
          w_state_nx = RUN;
        end
      end
      RUN: begin
        if (!pause) begin
          w_x_nx    = w_f;
          w_op_nx   = r_step;
          w_rv_nx   = 1'b1;
          w_y_nx    = y ^ w_f;
          w_z_nx    = z | w_f;
          w_step_nx = r_step + 2'b01;
          if (r_step == c_last_step) begin
            w_done_nx  = 1'b1;
            w_busy_nx  = 1'b0;
            w_state_nx = IDLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_step_nx  = 2'b00;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step       <= 2'b00;
      r_a          <= '0;
      r_b          <= '0;
      busy         <= 1'b0;
      op           <= 2'b00;
      x            <= '0;
      result_valid <= 1'b0;
      y            <= '0;
      z            <= '0;
      done         <= 1'b0;
    end else begin
      r_step       <= w_step_nx;
      r_a          <= w_a_nx;
      r_b          <= w_b_nx;
      busy         <= w_busy_nx;
      op           <= w_op_nx;
      x            <= w_x_nx;
      result_valid <= w_rv_nx;
      y            <= w_y_nx;
      z            <= w_z_nx;
      done         <= w_done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logic_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_op_sequencer
// Description : Directed and randomized sweeps checked against a sweep-level
//               model of the four logic ops and their XOR/OR accumulations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_op_sequencer;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             pause = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy, result_valid, done;
  logic [1:0]       op;
  logic [WIDTH-1:0] x, y, z;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] last_x, last_y, last_z;
  logic [1:0]       last_op;

  logic_op_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .a(a), .b(b),
    .busy(busy), .op(op), .x(x), .result_valid(result_valid),
    .y(y), .z(z), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                     input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input int k, input logic [WIDTH-1:0] ra,
                                              input logic [WIDTH-1:0] rb);
    case (k)
      0:       return ra & rb;
      1:       return ra | rb;
      2:       return ra ^ rb;
      default: return ~(ra & rb);
    endcase
  endfunction

  // One sweep: pmask bit n forces pause before result cycle n, pct adds random pauses,
  // noisy scribbles start/a/b while running. Returns in the done cycle.
  task automatic sweep(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic [15:0] pmask, input int pct, input bit noisy);
    logic [WIDTH-1:0] exp_r [4];
    logic [WIDTH-1:0] ey, ez;
    int k, cyc;
    bit p;
    ey = '0;
    ez = '0;
    for (int i = 0; i < 4; i++) begin
      exp_r[i] = ref_op(i, ta, tb_v);
      ey ^= exp_r[i];
      ez |= exp_r[i];
    end
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1; pause = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    chk("accept_busy", WIDTH'(busy), WIDTH'(1));
    chk("accept_y_clr", y, '0);
    chk("accept_z_clr", z, '0);
    chk("accept_rv", WIDTH'(result_valid), '0);
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 20) begin
      @(negedge clk);
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noisy) begin
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
      end
      p = pmask[cyc[3:0]] || (int'($urandom_range(0, 99)) < pct);
      pause = p;
      @(posedge clk); #1;
      cyc++;
      if (p) begin
        chk("pause_rv", WIDTH'(result_valid), '0);
        chk("pause_done", WIDTH'(done), '0);
        chk("pause_busy", WIDTH'(busy), WIDTH'(1));
      end else begin
        chk("res_rv", WIDTH'(result_valid), WIDTH'(1));
        chk("res_op", WIDTH'(op), WIDTH'(k));
        chk("res_x", x, exp_r[k]);
        chk("res_done", WIDTH'(done), WIDTH'(k == 3));
        chk("res_busy", WIDTH'(busy), WIDTH'(k != 3));
        k++;
      end
    end
    if (k < 4) chk("sweep_timeout", WIDTH'(k), WIDTH'(4));
    chk("final_y", y, ey);
    chk("final_z", z, ez);
    last_x = exp_r[3]; last_op = 2'b11; last_y = ey; last_z = ez;
    start = 1'b0;
  endtask

  // Idle cycles with random pause/a/b: nothing may move.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      pause = 1'($urandom_range(0, 1));
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      @(posedge clk); #1;
      chk("idle_busy", WIDTH'(busy), '0);
      chk("idle_rv", WIDTH'(result_valid), '0);
      chk("idle_done", WIDTH'(done), '0);
      chk("idle_x", x, last_x);
      chk("idle_op", WIDTH'(op), WIDTH'(last_op));
      chk("idle_y", y, last_y);
      chk("idle_z", z, last_z);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, WIDTH'(busy), '0);
    chk({tag, "_rv"}, WIDTH'(result_valid), '0);
    chk({tag, "_done"}, WIDTH'(done), '0);
    chk({tag, "_op"}, WIDTH'(op), '0);
    chk({tag, "_x"}, x, '0);
    chk({tag, "_y"}, y, '0);
    chk({tag, "_z"}, z, '0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;
    last_x = '0; last_op = 2'b00; last_y = '0; last_z = '0;
    idle(2);

    // Basic sweep: 00F0,0FF0,0F00,FF0F -> y=FF0F, z=FFFF
    sweep(16'h00F0, 16'h0FF0, 16'h0000, 0, 1'b0);
    chk("t1_y", y, 16'hFF0F);
    chk("t1_z", z, 16'hFFFF);
    idle(2);

    // Pauses at E2 and E3
    sweep(16'h00F0, 16'h0FF0, 16'h0006, 0, 1'b0);
    idle(1);

    // start/a/b noise during the sweep
    sweep(16'h00F0, 16'h0FF0, 16'h0000, 0, 1'b1);
    chk("t3_y", y, 16'hFF0F);
    idle(1);

    // Reset between E2 and E3
    @(negedge clk);
    a = 16'h1234; b = 16'hABCD; start = 1'b1; pause = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_vals("async_rst");
    @(negedge clk);
    reset = 1'b0;
    last_x = '0; last_op = 2'b00; last_y = '0; last_z = '0;
    idle(6);
    sweep(16'h5A5A, 16'h0FF0, 16'h0000, 0, 1'b0);
    idle(1);

    // Back-to-back: second start lands in the done cycle
    sweep(16'hC3C3, 16'h3C0F, 16'h0000, 0, 1'b0);
    sweep(16'h0001, 16'h8001, 16'h0000, 0, 1'b0);
    idle(1);

    // Extreme operands
    sweep(16'hFFFF, 16'h0000, 16'h0000, 0, 1'b0);
    chk("t6_y", y, 16'hFFFF);
    chk("t6_z", z, 16'hFFFF);
    idle(1);

    // Randomized sweeps
    for (int n = 0; n < 40; n++) begin
      sweep(WIDTH'($urandom), WIDTH'($urandom), 16'h0000, 30, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
